// File: rtl/decode_pkg.sv
// Shared opcode constants, immediate-format enum and the decoded packet layout
// used by the decode stage and its immediate decoder.
package decode_pkg;

  localparam int XLEN = 32;
  localparam int PC_W = 32;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_NONE} imm_fmt_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic            illegal;
  } decoded_pkt_t;

  function automatic imm_fmt_t opcode_fmt(input logic [6:0] op);
    case (op)
      OP_IMM, LOAD, JALR: opcode_fmt = FMT_I;
      STORE:              opcode_fmt = FMT_S;
      BRANCH:             opcode_fmt = FMT_B;
      LUI, AUIPC:         opcode_fmt = FMT_U;
      JAL:                opcode_fmt = FMT_J;
      OP:                 opcode_fmt = FMT_R;
      default:            opcode_fmt = FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-to-rename bus of the decode stage: input handshake, flush and the
// decoded head packet presented to rename.
interface decode_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_uses_rs1;
  logic            out_uses_rs2;
  logic            out_writes_rd;
  logic            out_illegal;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_uses_rs1, out_uses_rs2,
           out_writes_rd, out_illegal
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_uses_rs1, out_uses_rs2,
           out_writes_rd, out_illegal
  );
endinterface

// File: rtl/rv_imm_decode.sv
// Combinational RV32I immediate decoder: classifies the opcode into a format
// and builds the sign-extended immediate (zero for R-type and unknown opcodes).
module rv_imm_decode
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]             instr,
  output imm_fmt_t                fmt,
  output logic signed [XLEN-1:0]  imm
);

  always_comb begin
    fmt = opcode_fmt(instr[6:0]);
    imm = '0;
    case (fmt)
      FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
      FMT_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes the incoming instruction and holds decoded packets in a
// two-entry skid buffer presented to rename, with flush on redirect.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  decode_if.slave  bus
);

  imm_fmt_t                fmt_p0;
  logic signed [XLEN-1:0]  imm_p0;
  decoded_pkt_t            pkt_p0;

  decoded_pkt_t            buf_p1 [DEPTH];
  decoded_pkt_t            head_p1;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic                    push;
  logic                    pop;

  // p0: combinational decode of the incoming instruction
  rv_imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .instr (bus.in_instr),
    .fmt   (fmt_p0),
    .imm   (imm_p0)
  );

  always_comb begin
    pkt_p0           = '0;
    pkt_p0.pc        = bus.in_pc;
    pkt_p0.opcode    = bus.in_instr[6:0];
    pkt_p0.rd        = bus.in_instr[11:7];
    pkt_p0.rs1       = bus.in_instr[19:15];
    pkt_p0.rs2       = bus.in_instr[24:20];
    pkt_p0.funct3    = bus.in_instr[14:12];
    pkt_p0.funct7    = bus.in_instr[31:25];
    pkt_p0.imm       = imm_p0;
    pkt_p0.uses_rs1  = fmt_p0 inside {FMT_I, FMT_S, FMT_B, FMT_R};
    pkt_p0.uses_rs2  = fmt_p0 inside {FMT_S, FMT_B, FMT_R};
    pkt_p0.writes_rd = (fmt_p0 inside {FMT_I, FMT_U, FMT_J, FMT_R}) && (bus.in_instr[11:7] != 5'd0);
    pkt_p0.illegal   = (fmt_p0 == FMT_NONE);
  end

  assign bus.in_ready  = (count < 2'(DEPTH));
  assign bus.out_valid = (count != 2'd0);
  assign push = bus.in_valid & bus.in_ready & ~bus.flush;
  assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

  // p1: skid buffer; flush wins over any same-cycle push or pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_p1[i] <= '0;
    end else if (bus.flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        buf_p1[wr_ptr] <= pkt_p0;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_p1           = buf_p1[rd_ptr];
  assign bus.out_pc        = PC_W'(head_p1.pc);
  assign bus.out_opcode    = head_p1.opcode;
  assign bus.out_rd        = head_p1.rd;
  assign bus.out_rs1       = head_p1.rs1;
  assign bus.out_rs2       = head_p1.rs2;
  assign bus.out_funct3    = head_p1.funct3;
  assign bus.out_funct7    = head_p1.funct7;
  assign bus.out_imm       = XLEN'(head_p1.imm);
  assign bus.out_uses_rs1  = head_p1.uses_rs1;
  assign bus.out_uses_rs2  = head_p1.uses_rs2;
  assign bus.out_writes_rd = head_p1.writes_rd;
  assign bus.out_illegal   = head_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected packets queued at push, compared
// in order as rename accepts them.
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_if #(.XLEN(32), .PC_W(32)) bus ();

  decode_stage #(.XLEN(32), .PC_W(32), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  decoded_pkt_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ctl_of(input decoded_pkt_t p);
    return 64'({p.opcode, p.rd, p.rs1, p.rs2, p.funct3, p.funct7,
                p.uses_rs1, p.uses_rs2, p.writes_rd, p.illegal});
  endfunction

  // Reference decode written with arithmetic shifts on the raw word
  function automatic decoded_pkt_t model(input logic [31:0] i, input logic [31:0] pc);
    decoded_pkt_t p;
    logic signed [31:0] s;
    p = '0;
    s = i;
    p.pc = pc; p.opcode = i[6:0]; p.rd = i[11:7]; p.rs1 = i[19:15];
    p.rs2 = i[24:20]; p.funct3 = i[14:12]; p.funct7 = i[31:25];
    case (i[6:0])
      7'h13, 7'h03, 7'h67: begin
        p.imm = s >>> 20; p.uses_rs1 = 1'b1; p.writes_rd = (i[11:7] != 0);
      end
      7'h23: begin
        p.imm = $signed({i[31:25], i[11:7], 20'b0}) >>> 20; p.uses_rs1 = 1'b1; p.uses_rs2 = 1'b1;
      end
      7'h63: begin
        p.imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}) >>> 19;
        p.uses_rs1 = 1'b1; p.uses_rs2 = 1'b1;
      end
      7'h37, 7'h17: begin
        p.imm = {i[31:12], 12'h000}; p.writes_rd = (i[11:7] != 0);
      end
      7'h6f: begin
        p.imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}) >>> 11;
        p.writes_rd = (i[11:7] != 0);
      end
      7'h33: begin
        p.imm = '0; p.uses_rs1 = 1'b1; p.uses_rs2 = 1'b1; p.writes_rd = (i[11:7] != 0);
      end
      default: p.illegal = 1'b1;
    endcase
    return p;
  endfunction

  always @(negedge clk) begin
    decoded_pkt_t e;
    if (!reset && bus.out_valid && bus.out_ready && !bus.flush) begin
      n_pop++;
      if (sb.size() == 0) begin
        chk("sb_empty_on_pop", 64'(bus.out_pc), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("out_pc", 64'(bus.out_pc), 64'(e.pc));
        chk("out_imm", 64'(bus.out_imm), 64'(e.imm));
        chk("out_ctl", 64'({bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2,
                            bus.out_funct3, bus.out_funct7, bus.out_uses_rs1,
                            bus.out_uses_rs2, bus.out_writes_rd, bus.out_illegal}),
            ctl_of(e));
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input decoded_pkt_t exp);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      guard++;
      if (guard > 100) begin
        chk("send_timeout", 64'(guard), 64'd0);
        break;
      end
    end
    if (guard <= 100) sb.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] dir_instr [6] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3,
                                 32'h123452B7, 32'h0000007F, 32'h00208033};
  logic [31:0] dir_imm   [6] = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC,
                                 32'h12345000, 32'h00000000, 32'h00000000};
  logic [6:0]  ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    decoded_pkt_t e;
    logic [31:0] r;
    int base;
    bit done;

    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_out_opcode", 64'(bus.out_opcode), 64'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Directed decode, streaming with rename always ready
    for (int k = 0; k < 6; k++) begin
      e = model(dir_instr[k], 32'h1000 + 32'(4 * k));
      e.imm = dir_imm[k];
      send(dir_instr[k], 32'h1000 + 32'(4 * k), e);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("dir_drained", 64'(sb.size()), 64'd0);

    // Backpressure: two pushes fill the buffer, third waits
    bus.out_ready = 1'b0;
    send(32'h00500113, 32'h2000, model(32'h00500113, 32'h2000));
    send(32'h00628233, 32'h2004, model(32'h00628233, 32'h2004));
    fork
      send(32'h0040006F, 32'h2008, model(32'h0040006F, 32'h2008));
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
          chk("bp_head_pc", 64'(bus.out_pc), 64'h2000);
          chk("bp_head_imm", 64'(bus.out_imm), 64'd5);
        end
        @(posedge clk); #1;
        base = n_pop;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        chk("bp_drain_rate", 64'(n_pop - base), 64'd3);
      end
    join

    // Flush at count=2 with a concurrent incoming packet
    bus.out_ready = 1'b0;
    send(32'h00A00093, 32'h3000, model(32'h00A00093, 32'h3000));
    send(32'h00B00093, 32'h3004, model(32'h00B00093, 32'h3004));
    bus.in_valid = 1'b1; bus.in_instr = 32'h00C00093; bus.in_pc = 32'h3008;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush2_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush2_in_ready", 64'(bus.in_ready), 64'd1);
    base = n_pop;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush2_no_output", 64'(n_pop - base), 64'd0);

    // Flush at count=1: a push that would otherwise be accepted is dropped
    bus.out_ready = 1'b0;
    send(32'h00D00093, 32'h3100, model(32'h00D00093, 32'h3100));
    bus.in_valid = 1'b1; bus.in_instr = 32'h00E00093; bus.in_pc = 32'h3104;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush1_out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset between clock edges
    bus.out_ready = 1'b0;
    send(32'h00F00093, 32'h4000, model(32'h00F00093, 32'h4000));
    @(posedge clk); #3;
    chk("pre_areset_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("areset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("areset_out_pc", 64'(bus.out_pc), 64'd0);
    sb.delete();
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;

    // Random stream with random rename backpressure
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          r = $urandom();
          r[6:0] = ops[$urandom_range(0, 9)];
          send(r, 32'h8000 + 32'(4 * k), model(r, 32'h8000 + 32'(4 * k)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("sb_leftover", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
